donut_anim_ctrl: RTL

// - Frame-rate animation sequencer for the donut VGA renderer. Once per frame it computes the donut origin
//   (org_x/org_y), the 6-bit {R,G,B} colour and the sprinkle enable mask; the pixel datapath subtracts the

---
 rtl/donut_anim_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/donut_anim_ctrl.sv
// rtl/donut_anim_ctrl.sv - frame-rate origin/colour/sprinkle sequencer for the donut renderer (optional feature macro: ANIM_SPRINKLE_EN)
module donut_anim_ctrl #(
    parameter int X_MIN           = 100,
    parameter int X_MAX           = 540,
    parameter int Y_MIN           = 80,
    parameter int Y_MAX           = 400,
    parameter int X_INIT          = 320,
    parameter int Y_INIT          = 240,
    parameter int COLOR_PERIOD    = 32,
    parameter int SPRINKLE_N      = 8,
    parameter int SPRINKLE_PERIOD = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic [1:0]            cfg_speed,
    input  logic                  cfg_pause,
    output logic [9:0]            org_x,
    output logic [9:0]            org_y,
    output logic [5:0]            color,
    output logic [SPRINKLE_N-1:0] sprinkle_mask,
    output logic [7:0]            frame_cnt,
    output logic                  upd
);

    // S_HOLD vs S_RUN doubles as the shadowed pause bit
    typedef enum logic [1:0] {S_WAIT, S_RUN, S_HOLD} state_t;

    localparam int          CCW = (COLOR_PERIOD > 1) ? $clog2(COLOR_PERIOD) : 1;
    localparam logic [10:0] XLO = 11'(X_MIN);
    localparam logic [10:0] XHI = 11'(X_MAX);
    localparam logic [10:0] YLO = 11'(Y_MIN);
    localparam logic [10:0] YHI = 11'(Y_MAX);

    state_t         state_q, state_d;
    logic [9:0]     org_x_q, org_x_d, org_y_q, org_y_d;
    logic           dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [1:0]     pal_idx_q, pal_idx_d;
    logic [CCW-1:0] col_cnt_q, col_cnt_d;
    logic [1:0]     spd_q, spd_d;
    logic [7:0]     frame_cnt_q, frame_cnt_d;
    logic           upd_q, upd_d;
    logic [5:0]     color_c;

`ifdef ANIM_SPRINKLE_EN
    localparam int SCW = (SPRINKLE_PERIOD > 1) ? $clog2(SPRINKLE_PERIOD) : 1;
    logic [SCW-1:0]        spr_cnt_q, spr_cnt_d;
    logic [SPRINKLE_N-1:0] mask_q, mask_d;
`endif

    // One bounce step on an axis: returns {dir_up, new_pos}; compares are 11 bits so nothing wraps
    function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic dir_up,
                                              input logic [1:0] spd, input logic [10:0] lo,
                                              input logic [10:0] hi);
        logic [10:0] p, s;
        logic [9:0]  r;
        logic        d;
        p = {1'b0, pos};
        s = {9'b0, spd};
        r = pos;
        d = dir_up;
        if (spd != 2'd0) begin
            if (dir_up) begin
                if (p + s >= hi) begin
                    r = hi[9:0];
                    d = 1'b0;
                end else begin
                    r = pos + {8'b0, spd};
                end
            end else begin
                if (p <= lo + s) begin
                    r = lo[9:0];
                    d = 1'b1;
                end else begin
                    r = pos - {8'b0, spd};
                end
            end
        end
        return {d, r};
    endfunction

    // Next-state: everything moves only on frame_start; motion/colour only when the shadowed pause is clear
    always_comb begin
        state_d     = state_q;
        org_x_d     = org_x_q;
        org_y_d     = org_y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        pal_idx_d   = pal_idx_q;
        col_cnt_d   = col_cnt_q;
        spd_d       = spd_q;
        frame_cnt_d = frame_cnt_q;
        upd_d       = frame_start;
`ifdef ANIM_SPRINKLE_EN
        spr_cnt_d   = spr_cnt_q;
        mask_d      = mask_q;
`endif
        if (frame_start) begin
            spd_d   = cfg_speed;
            state_d = cfg_pause ? S_HOLD : S_RUN;
            if (state_q != S_WAIT) begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
            if (state_q == S_RUN) begin
                {dir_x_d, org_x_d} = axis_step(org_x_q, dir_x_q, spd_q, XLO, XHI);
                {dir_y_d, org_y_d} = axis_step(org_y_q, dir_y_q, spd_q, YLO, YHI);
                if (col_cnt_q == CCW'(COLOR_PERIOD - 1)) begin
                    col_cnt_d = '0;
                    pal_idx_d = pal_idx_q + 2'd1;
                end else begin
                    col_cnt_d = col_cnt_q + CCW'(1);
                end
`ifdef ANIM_SPRINKLE_EN
                if (spr_cnt_q == SCW'(SPRINKLE_PERIOD - 1)) begin
                    spr_cnt_d = '0;
                    mask_d    = {mask_q[SPRINKLE_N-2:0], mask_q[SPRINKLE_N-1]};
                end else begin
                    spr_cnt_d = spr_cnt_q + SCW'(1);
                end
`endif
            end
        end
    end

    // State register with synchronous active-low reset; reset beats a coincident frame_start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_WAIT;
            org_x_q     <= 10'(X_INIT);
            org_y_q     <= 10'(Y_INIT);
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            pal_idx_q   <= 2'd0;
            col_cnt_q   <= '0;
            spd_q       <= 2'd0;
            frame_cnt_q <= 8'd0;
            upd_q       <= 1'b0;
`ifdef ANIM_SPRINKLE_EN
            spr_cnt_q   <= '0;
            mask_q      <= SPRINKLE_N'(1);
`endif
        end else begin
            state_q     <= state_d;
            org_x_q     <= org_x_d;
            org_y_q     <= org_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            pal_idx_q   <= pal_idx_d;
            col_cnt_q   <= col_cnt_d;
            spd_q       <= spd_d;
            frame_cnt_q <= frame_cnt_d;
            upd_q       <= upd_d;
`ifdef ANIM_SPRINKLE_EN
            spr_cnt_q   <= spr_cnt_d;
            mask_q      <= mask_d;
`endif
        end
    end

    // Palette lookup from the registered index, so colour also only changes at frame boundaries
    always_comb begin
        color_c = 6'b111111;
        case (pal_idx_q)
            2'd0: color_c = 6'b111111;
            2'd1: color_c = 6'b110110;
            2'd2: color_c = 6'b100100;
            2'd3: color_c = 6'b011111;
            default: color_c = 6'b111111;
        endcase
    end

    assign org_x     = org_x_q;
    assign org_y     = org_y_q;
    assign color     = color_c;
    assign frame_cnt = frame_cnt_q;
    assign upd       = upd_q;
`ifdef ANIM_SPRINKLE_EN
    assign sprinkle_mask = mask_q;
`else
    assign sprinkle_mask = {SPRINKLE_N{1'b1}};
`endif

endmodule
